// File: rtl/meas_frame_tx.sv
// Latches LFSR-coded frequency-counter measurements and serializes each into a
// 17-byte sync/seq/flags/counts/checksum frame on a byte-wide valid/ready stream.
module meas_frame_tx #(
  parameter logic [7:0] SYNC0 = 8'hA5,
  parameter logic [7:0] SYNC1 = 8'h5A
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        meas_ready,
  input  logic [31:0] sig_sys_cnt,
  input  logic [31:0] sig_cnt,
  input  logic [31:0] ref_sys_cnt,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  localparam int unsigned IDX_W    = 5;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned MEAS_W   = 96;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(16);

  typedef struct packed {
    logic [31:0] sig_sys;
    logic [31:0] sig;
    logic [31:0] ref_sys;
  } meas_t;

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BYTE_W-1:0]   seq_q, seq_d;
  logic                ovf_q, ovf_d;
  logic [BYTE_W-1:0]   ovr_cnt_q, ovr_cnt_d;
  logic                pend_vld_q, pend_vld_d;
  meas_t               pend_q, pend_d;
  meas_t               act_q, act_d;
  logic [BYTE_W-1:0]   act_seq_q, act_seq_d;
  logic                act_flag_q, act_flag_d;
  logic [BYTE_W-1:0]   act_csum_q, act_csum_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;

  meas_t meas_in;
  meas_t load_src;
  logic  load;
  logic  xfer;

  assign meas_in = meas_t'({sig_sys_cnt, sig_cnt, ref_sys_cnt});

  // Checksum over seq, flags and the twelve count bytes, computed once at load.
  function automatic logic [BYTE_W-1:0] frame_csum(input meas_t m, input logic [BYTE_W-1:0] seq,
                                                   input logic flag);
    logic [MEAS_W-1:0] cat;
    logic [BYTE_W-1:0] sum;
    cat = m;
    sum = seq + {7'b0, flag};
    for (int i = 0; i < 12; i++) begin
      sum = sum + cat[8*i +: 8];
    end
    return sum;
  endfunction

  function automatic logic [BYTE_W-1:0] frame_byte(input logic [IDX_W-1:0] idx, input meas_t m,
                                                   input logic [BYTE_W-1:0] seq, input logic flag,
                                                   input logic [BYTE_W-1:0] csum);
    logic [MEAS_W-1:0] sh;
    logic [BYTE_W-1:0] b;
    sh = MEAS_W'(m) << {idx - IDX_W'(4), 3'b000};
    case (idx)
      IDX_W'(0):  b = SYNC0;
      IDX_W'(1):  b = SYNC1;
      IDX_W'(2):  b = seq;
      IDX_W'(3):  b = {7'b0, flag};
      IDX_W'(16): b = csum;
      default:    b = (idx >= IDX_W'(4) && idx <= IDX_W'(15)) ? sh[MEAS_W-1 -: 8] : 8'h00;
    endcase
    return b;
  endfunction

  // Next-state: frame sequencing, pending slot and overrun accounting.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    ovf_d      = ovf_q;
    ovr_cnt_d  = ovr_cnt_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    act_d      = act_q;
    act_seq_d  = act_seq_q;
    act_flag_d = act_flag_q;
    act_csum_d = act_csum_q;
    tx_data_d  = '0;
    load       = 1'b0;
    load_src   = meas_in;
    xfer       = (state_q == SEND) && tx_ready;

    case (state_q)
      IDLE: begin
        if (meas_ready) begin
          load = 1'b1;
        end
      end
      SEND: begin
        if (xfer && idx_q == LAST_IDX) begin
          if (pend_vld_q) begin
            load       = 1'b1;
            load_src   = pend_q;
            pend_vld_d = meas_ready;
            if (meas_ready) begin
              pend_d = meas_in;
            end
          end else if (meas_ready) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (meas_ready) begin
            pend_d     = meas_in;
            pend_vld_d = 1'b1;
            // Newest wins; the displaced measurement is counted as dropped.
            if (pend_vld_q) begin
              ovf_d = 1'b1;
              if (ovr_cnt_q != 8'hFF) begin
                ovr_cnt_d = ovr_cnt_q + 8'd1;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (load) begin
      state_d    = SEND;
      idx_d      = '0;
      act_d      = load_src;
      act_seq_d  = seq_q;
      seq_d      = seq_q + 8'd1;
      act_flag_d = ovf_q;
      ovf_d      = 1'b0;
      act_csum_d = frame_csum(load_src, seq_q, ovf_q);
    end

    if (state_d == SEND) begin
      tx_data_d = frame_byte(idx_d, act_d, act_seq_d, act_flag_d, act_csum_d);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      seq_q      <= '0;
      ovf_q      <= 1'b0;
      ovr_cnt_q  <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      act_q      <= '0;
      act_seq_q  <= '0;
      act_flag_q <= 1'b0;
      act_csum_q <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      ovf_q      <= ovf_d;
      ovr_cnt_q  <= ovr_cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      act_seq_q  <= act_seq_d;
      act_flag_q <= act_flag_d;
      act_csum_q <= act_csum_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = (state_q == SEND);
  assign busy        = (state_q == SEND);
  assign overrun_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_meas_frame_tx.sv
// Scoreboard bench for meas_frame_tx: expected frame bytes are queued when a
// measurement is driven and compared by a stream monitor as bytes appear.
module tb_meas_frame_tx;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meas_ready = 1'b0;
  logic [31:0] sig_sys_cnt = '0;
  logic [31:0] sig_cnt = '0;
  logic [31:0] ref_sys_cnt = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];

  always #5 sys_clk = ~sys_clk;

  meas_frame_tx dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .meas_ready  (meas_ready),
    .sig_sys_cnt (sig_sys_cnt),
    .sig_cnt     (sig_cnt),
    .ref_sys_cnt (ref_sys_cnt),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] seq, input logic fl,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [7:0]  f[17];
    logic [95:0] cat;
    logic [7:0]  sum;
    cat  = {a, b, c};
    f[0] = 8'hA5;
    f[1] = 8'h5A;
    f[2] = seq;
    f[3] = {7'b0, fl};
    for (int i = 0; i < 12; i++) f[4+i] = cat[95-8*i -: 8];
    sum = 8'h00;
    for (int i = 2; i < 16; i++) sum = sum + f[i];
    f[16] = sum;
    for (int i = 0; i < 17; i++) exp_q.push_back(f[i]);
  endtask

  task automatic pulse(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    meas_ready  = 1'b1;
    sig_sys_cnt = a;
    sig_cnt     = b;
    ref_sys_cnt = c;
    tick();
    meas_ready  = 1'b0;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    meas_ready = 1'b0;
    tx_ready   = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_drain(input int limit);
    int c = 0;
    while ((tx_valid || exp_q.size() != 0) && c < limit) begin
      tick();
      c++;
    end
    n_checks++;
    if (tx_valid || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: tx_valid=%0b, %0d bytes outstanding after %0d cycles, required idle with none",
               tx_valid, exp_q.size(), limit);
    end
  endtask

  task automatic run_valid(input int limit, input bit toggle, output int cyc);
    cyc = 0;
    while (tx_valid && cyc < limit) begin
      if (toggle) tx_ready = (cyc % 2 == 0);
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({tx_valid, busy, tx_data, overrun_cnt} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b busy=%0b data=%02h ovr=%0d, required all zero",
               tx_valid, busy, tx_data, overrun_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int cyc;
    do_reset();
    push_frame(8'h00, 1'b0, 32'h1, 32'h2, 32'h3);
    pulse(32'h1, 32'h2, 32'h3);
    n_checks++;
    if (tx_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: valid=%0b busy=%0b, required 1 1", tx_valid, busy);
    end
    run_valid(60, 1'b0, cyc);
    n_checks++;
    if (cyc != 17) begin
      n_fail++;
      $display("FAIL single_length: %0d valid cycles, required 17", cyc);
    end
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: valid=%0b busy=%0b, required 0 0", tx_valid, busy);
    end
    wait_drain(10);
  endtask

  task automatic test_backpressure;
    int cyc;
    do_reset();
    push_frame(8'h00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    pulse(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_valid(100, 1'b1, cyc);
    n_checks++;
    if (cyc != 33) begin
      n_fail++;
      $display("FAIL backpressure_length: %0d valid cycles, required 33", cyc);
    end
    wait_drain(10);
  endtask

  task automatic test_pending_overrun;
    int cyc;
    do_reset();
    push_frame(8'h00, 1'b0, 32'h1, 32'h2, 32'h3);
    push_frame(8'h01, 1'b1, 32'h100, 32'h200, 32'h300);
    pulse(32'h1, 32'h2, 32'h3);
    pulse(32'h10, 32'h20, 32'h30);
    pulse(32'h100, 32'h200, 32'h300);
    run_valid(100, 1'b0, cyc);
    n_checks++;
    if (cyc != 32) begin
      n_fail++;
      $display("FAIL back_to_back: %0d further valid cycles, required 32", cyc);
    end
    n_checks++;
    if (overrun_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL overrun_one: overrun_cnt=%0d, required 1", overrun_cnt);
    end
    wait_drain(10);
    push_frame(8'h02, 1'b0, 32'h7, 32'h8, 32'h9);
    pulse(32'h7, 32'h8, 32'h9);
    wait_drain(40);
    n_checks++;
    if (overrun_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL overrun_hold: overrun_cnt=%0d, required 1", overrun_cnt);
    end
  endtask

  task automatic test_simul_drain;
    do_reset();
    push_frame(8'h00, 1'b0, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF);
    push_frame(8'h01, 1'b0, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666);
    pulse(32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF);
    repeat (16) tick();
    pulse(32'h1111_2222, 32'h3333_4444, 32'h5555_6666);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL simul_drain: valid=%0b data=%02h, required 1 A5", tx_valid, tx_data);
    end
    n_checks++;
    if (overrun_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL simul_drain_ovr: overrun_cnt=%0d, required 0", overrun_cnt);
    end
    wait_drain(40);
  endtask

  task automatic test_last_edge_pending;
    do_reset();
    push_frame(8'h00, 1'b0, 32'hA, 32'hA, 32'hA);
    push_frame(8'h01, 1'b0, 32'hB, 32'hB, 32'hB);
    push_frame(8'h02, 1'b0, 32'hC, 32'hC, 32'hC);
    pulse(32'hA, 32'hA, 32'hA);
    pulse(32'hB, 32'hB, 32'hB);
    repeat (15) tick();
    pulse(32'hC, 32'hC, 32'hC);
    n_checks++;
    if (overrun_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL last_edge_pending_ovr: overrun_cnt=%0d, required 0", overrun_cnt);
    end
    wait_drain(80);
  endtask

  task automatic test_wrap_saturate;
    do_reset();
    for (int k = 0; k < 257; k++) begin
      push_frame(8'(k), 1'b0, 32'(k), ~32'(k), 32'(k * 3));
      pulse(32'(k), ~32'(k), 32'(k * 3));
      wait_drain(40);
    end
    tx_ready = 1'b0;
    push_frame(8'h01, 1'b0, 32'hCAFE_0000, 32'h0, 32'h0);
    pulse(32'hCAFE_0000, 32'h0, 32'h0);
    for (int i = 1; i <= 301; i++) begin
      pulse(32'(i), 32'(i + 1000), 32'(i + 2000));
      if (i == 255) begin
        n_checks++;
        if (overrun_cnt !== 8'd254) begin
          n_fail++;
          $display("FAIL overrun_count: overrun_cnt=%0d, required 254", overrun_cnt);
        end
      end
    end
    n_checks++;
    if (overrun_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL overrun_saturate: overrun_cnt=%0d, required 255", overrun_cnt);
    end
    push_frame(8'h02, 1'b1, 32'd301, 32'd1301, 32'd2301);
    tx_ready = 1'b1;
    wait_drain(80);
  endtask

  task automatic test_reset_mid;
    do_reset();
    push_frame(8'h00, 1'b0, 32'h5, 32'h6, 32'h7);
    pulse(32'h5, 32'h6, 32'h7);
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%0b busy=%0b, required 0 0", tx_valid, busy);
    end
    rst_n = 1'b1;
    exp_q.delete();
    tick();
    push_frame(8'h00, 1'b0, 32'h9, 32'hA, 32'hB);
    pulse(32'h9, 32'hA, 32'hB);
    wait_drain(40);
  endtask

  initial begin
    fork
      forever begin
        @(negedge sys_clk);
        if (rst_n && tx_valid) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL stream_extra: got byte %02h, none expected", tx_data);
          end else begin
            if (tx_data !== exp_q[0]) begin
              n_fail++;
              $display("FAIL stream_byte: got %02h, required %02h (ready=%0b)",
                       tx_data, exp_q[0], tx_ready);
            end
            if (tx_ready) void'(exp_q.pop_front());
          end
        end
      end
    join_none

    test_reset();
    test_single();
    test_backpressure();
    test_pending_overrun();
    test_simul_drain();
    test_last_edge_pending();
    test_wrap_saturate();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
